// File: rtl/psg_write_queue.sv
// Buffers host command bytes and replays them onto the PSG data bus/WE_n, one strobe per GAP cycles.
// Pop one cycle after a byte lands; in_ready drops only while all DEPTH entries are occupied.
module psg_write_queue #(
    parameter int DEPTH = 8,
    parameter int GAP   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_data,
    output logic                     out_we_n,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (GAP > 2) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  count_q, count_d;
    logic [CW-1:0]  gap_q, gap_d;
    logic [7:0]     data_q, data_d;
    logic           we_n_q, we_n_d;
    logic [7:0]     mem_q [DEPTH];
    logic           push;
    logic           pop;

    // Ready comes from the registered count only, so a pop frees space a cycle later.
    assign in_ready = (count_q != LW'(DEPTH));
    assign push     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        data_d  = data_q;
        we_n_d  = 1'b1;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    we_n_d  = 1'b0;
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                if (GAP == 2) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d   = CW'(GAP - 2);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Leaving on the last count keeps strobe-to-strobe spacing at exactly GAP.
                gap_d = gap_q - CW'(1);
                if (gap_q == CW'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gap_q    <= '0;
            data_q   <= 8'h00;
            we_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
            data_q   <= data_d;
            we_n_q   <= we_n_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_data = data_q;
    assign out_we_n = we_n_q;
    assign level    = count_q;
    assign busy     = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_psg_write_queue.sv
// Randomized and directed bench for psg_write_queue with a queue-based timing model.
module tb_psg_write_queue;

    localparam int DEPTH = 8;
    localparam int GAP   = 32;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_we_n;
    logic [LW-1:0] level;
    logic          busy;

    always #5 clk = ~clk;

    psg_write_queue #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_we_n (out_we_n),
        .level    (level),
        .busy     (busy)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    bit         started = 1'b0;

    // Model: a byte queue plus the edge index of the most recent pop.
    logic [7:0] mq[$];
    int         last_pop = 0;
    bit         have_pop = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         m_we_n = 1'b1;
    bit         acc_last = 1'b0;

    int         log_cyc[$];
    logic [7:0] log_dat[$];
    int         max_lvl = 0;
    bit         saw_full = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, exp);
    endtask

    always @(posedge clk) begin
        int n;
        bit popped;
        cyc++;
        if (reset) begin
            started  = 1'b1;
            mq.delete();
            have_pop = 1'b0;
            m_data   = 8'h00;
            m_we_n   = 1'b1;
            acc_last = 1'b0;
        end else begin
            n      = mq.size();
            popped = 1'b0;
            if (n > 0 && (!have_pop || cyc >= last_pop + GAP)) begin
                m_data   = mq.pop_front();
                popped   = 1'b1;
                last_pop = cyc;
                have_pop = 1'b1;
            end
            acc_last = in_valid && (n != DEPTH);
            if (acc_last) mq.push_back(in_data);
            m_we_n = !popped;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("we_n", {31'd0, out_we_n}, {31'd0, m_we_n});
            chk("out_data", {24'd0, out_data}, {24'd0, m_data});
            chk("level", {{(32-LW){1'b0}}, level}, mq.size());
            chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() != DEPTH});
            chk("busy", {31'd0, busy},
                {31'd0, (mq.size() != 0) || (have_pop && cyc < last_pop + GAP - 1)});
            if (out_we_n === 1'b0) begin
                log_cyc.push_back(cyc);
                log_dat.push_back(out_data);
            end
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (level == LW'(DEPTH) && in_ready === 1'b0) saw_full = 1'b1;
        end
    end

    task automatic push_byte(input logic [7:0] b, output int k);
        k        = -1;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (acc_last) begin
                k = cyc;
                break;
            end
        end
        in_valid = 1'b0;
        chk("push_accepted", {31'd0, k >= 0}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 3000 && busy !== 1'b0; t++) @(negedge clk);
        chk("idle_reached", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_dat.delete();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog at cycle %0d: got no finish, required finish", cyc);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         k;
        int         k2;
        int         rate;
        logic [7:0] b;
        logic [7:0] expq[$];

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_we_n", {31'd0, out_we_n}, 32'd1);
        chk("rst_level", {{(32-LW){1'b0}}, level}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte latency and busy fall.
        clear_log();
        push_byte(8'h9F, k);
        @(negedge clk);
        chk("single_we_n", {31'd0, out_we_n}, 32'd0);
        chk("single_data", {24'd0, out_data}, 32'h9F);
        chk("single_level", {{(32-LW){1'b0}}, level}, 32'd0);
        wait_until(k + 1 + GAP - 2);
        chk("single_busy_hold", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("single_busy_fall", {31'd0, busy}, 32'd0);
        wait_idle();

        // Burst of three.
        clear_log();
        max_lvl = 0;
        push_byte(8'h80, k);
        push_byte(8'h3F, k);
        push_byte(8'h90, k);
        wait_idle();
        chk("burst_count", log_cyc.size(), 32'd3);
        if (log_cyc.size() == 3) begin
            chk("burst_d0", {24'd0, log_dat[0]}, 32'h80);
            chk("burst_d1", {24'd0, log_dat[1]}, 32'h3F);
            chk("burst_d2", {24'd0, log_dat[2]}, 32'h90);
            chk("burst_gap01", log_cyc[1] - log_cyc[0], 32'd32);
            chk("burst_gap12", log_cyc[2] - log_cyc[1], 32'd32);
        end
        chk("burst_peak", max_lvl, 32'd2);

        // Fill past DEPTH with a held offer.
        clear_log();
        saw_full = 1'b0;
        for (int i = 0; i < 12; i++) push_byte(8'(i), k);
        wait_idle();
        chk("full_seen", {31'd0, saw_full}, 32'd1);
        chk("full_count", log_dat.size(), 32'd12);
        for (int i = 0; i < 12 && i < log_dat.size(); i++)
            chk("full_order", {24'd0, log_dat[i]}, i);

        // Wrap-around in groups of three.
        clear_log();
        expq.delete();
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            push_byte(b, k);
            expq.push_back(b);
            if (i % 3 == 2 || i == 19) wait_idle();
        end
        chk("wrap_count", log_dat.size(), 32'd20);
        for (int i = 0; i < 20 && i < log_dat.size(); i++)
            chk("wrap_order", {24'd0, log_dat[i]}, {24'd0, expq[i]});

        // Push on the same edge as a pop from level 1.
        clear_log();
        push_byte(8'hA1, k);
        push_byte(8'hB2, k2);
        chk("simul_edge", k2, k + 1);
        chk("simul_level", {{(32-LW){1'b0}}, level}, 32'd1);
        chk("simul_we_n", {31'd0, out_we_n}, 32'd0);
        chk("simul_data", {24'd0, out_data}, 32'hA1);
        wait_idle();
        chk("simul_count", log_dat.size(), 32'd2);
        if (log_dat.size() == 2) begin
            chk("simul_next", {24'd0, log_dat[1]}, 32'hB2);
            chk("simul_gap", log_cyc[1] - log_cyc[0], 32'd32);
        end

        // Reset during a strobe with four bytes queued.
        push_byte(8'h10, k);
        for (int i = 1; i < 6; i++) push_byte(8'(8'h10 + i), k2);
        wait_until(k + 1 + GAP);
        chk("rstmid_strobe", {31'd0, out_we_n}, 32'd0);
        chk("rstmid_level", {{(32-LW){1'b0}}, level}, 32'd4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_we_n", {31'd0, out_we_n}, 32'd1);
        chk("rstmid_level0", {{(32-LW){1'b0}}, level}, 32'd0);
        chk("rstmid_data", {24'd0, out_data}, 32'h00);
        clear_log();
        repeat (80) @(negedge clk);
        chk("rstmid_quiet", log_dat.size(), 32'd0);
        push_byte(8'h5A, k);
        @(negedge clk);
        chk("rstmid_first_we_n", {31'd0, out_we_n}, 32'd0);
        chk("rstmid_first_data", {24'd0, out_data}, 32'h5A);
        wait_idle();

        // Randomized traffic with holds and occasional resets.
        rate = 3;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i % 500 == 0) rate = $urandom_range(1, 19);
            if (reset) reset = 1'b0;
            if (!(in_valid && !acc_last)) begin
                in_valid = ($urandom_range(0, 19) < rate);
                in_data  = 8'($urandom);
            end
            if ($urandom_range(0, 999) == 0) reset = 1'b1;
        end
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/psg_write_queue.md
# psg_write_queue

Write-pacing front end for the SN76489-compatible PSG core. It buffers command bytes from a host (CPU bus bridge, SPI slave or playback sequencer) through a valid/ready handshake. It replays them onto the PSG's 8-bit data bus and active-low /WE strobe, one byte per slot, with a guaranteed minimum spacing, so bursts of latch/data byte pairs never collide. Outputs drive the PSG core's data input and `uio_in[0]` /WE pin directly.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `GAP`, 32: minimum clk cycles from one strobe to the next; ≥2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `in_data`  in  8  command byte from host.
- `in_valid`  in  1  host offers `in_data`.
- `in_ready`  out  1  queue can accept; `= (level != DEPTH)`, combinational from registered count.
- `out_data`  out  8  byte presented to the PSG data bus.
- `out_we_n`  out  1  active-low write strobe to the PSG; low for exactly one cycle per byte.
- `level`  out  $clog2(DEPTH)+1  bytes currently queued, excluding the byte being strobed.
- `busy`  out  1  `state != IDLE || level != 0`.

## Operation
- Circular FIFO with read/write pointers of $clog2(DEPTH) bits plus a count register. Pointers wrap modulo DEPTH.
- Push: `in_valid && in_ready` at a rising edge writes `in_data` and increments `level`. Bytes offered while full are not taken; the host must hold them. They are never dropped.
- Pacer FSM, three states:
  - IDLE: if `level != 0`, pop the head into `out_data`, drive `out_we_n`=0 and go to STROBE. Otherwise stay, with `out_we_n`=1.
  - STROBE: lasts one cycle. Drive `out_we_n`=1, load the gap counter with GAP-2 and go to WAIT. If GAP==2, go directly to IDLE.
  - WAIT: decrement the counter. At 0, go to IDLE. `out_data` is held unchanged throughout.
- Simultaneous push and pop in one edge: `level` is unchanged and both pointers advance. When empty, a push is not bypassed to the output; it lands in the FIFO first.
- Byte order is strictly FIFO. No reordering, no merging of latch/data pairs.
- `out_data` holds the last strobed byte until the next pop. Its reset value is 0x00.

## Timing
- Reset values: `out_we_n`=1, `out_data`=0x00, `level`=0, `in_ready`=1, `busy`=0, state IDLE, pointers 0.
- Reset mid-operation: all queued bytes are discarded. If a strobe is in progress, `out_we_n` is 1 in the first cycle after the reset edge.
- Latency with the queue empty and the FSM in IDLE:
  - Byte accepted at edge k.
  - `level`=1 after edge k.
  - Pop at edge k+1, so `out_we_n` is low in the cycle after edge k+1.
  - `level` returns to 0 after edge k+1.
- Spacing: if a strobe is low in cycle T, the next strobe is low no earlier than cycle T+GAP. With a non-empty queue it is exactly T+GAP (back-to-back throughput of 1 byte per GAP cycles).
- `out_data` is stable from the strobe cycle until at least GAP-1 cycles after it. The PSG samples on the edge ending the strobe cycle.
- Full: `in_ready`=0 while `level`==DEPTH. A pop at edge e brings `in_ready` to 1 in the cycle after e, with no combinational path from pop to ready.
- `in_ready` never depends on `in_valid`.

## Test plan
- Single byte: after reset, push 0x9F at edge 5. Required: `out_we_n` low exactly in cycle after edge 6 with `out_data`=0x9F; `level` back to 0; `busy` falls after GAP-1 further cycles.
- Burst: push 0x80, 0x3F, 0x90 back-to-back with GAP=32. Required:
  - three strobes spaced exactly 32 cycles apart;
  - `out_data` sequence 0x80, 0x3F, 0x90;
  - `level` peaks at 2.
- Full/backpressure: with DEPTH=8, hold `in_valid` high with incrementing bytes 0x00..0x0B. Required:
  - `in_ready` deasserts at `level`=8;
  - no byte is lost or duplicated;
  - 12 strobes occur in order 0x00..0x0B.
- Wrap-around: push and drain 20 bytes in repeated groups of 3. Required: pointers wrap past DEPTH and output order matches input order exactly.
- Simultaneous push/pop: push a byte on the same edge the FSM pops from `level`=1. Required: `level` stays 1 and the next strobe carries the new byte.
- Reset mid-operation: assert reset during a strobe cycle with 4 bytes queued. Required:
  - `out_we_n`=1 and `level`=0 after the reset edge;
  - no further strobes until new pushes arrive;
  - first post-reset byte strobes with normal latency.
